icache_fetch_unit: RTL
======================

Name: icache_fetch_unit

Overview:
- Direct-mapped instruction cache between the program counter unit and the instruction memory.
- Takes the 32-bit PC from the PC stage and returns the 32-bit instruction to the decode/control path.
- On a miss it asserts BUSYWAIT to stall the PC stage and the register file.
- During the stall it fetches one 128-bit block from instruction memory through a read/busywait handshake.

Parameters:
- ADDR_BITS, 10: number of low PC byte-address bits used (1 KB instruction space). PC[31:ADDR_BITS] is ignored.
- NUM_BLOCKS, 8: number of cache lines (power of 2). Index width IW = log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4: 32-bit words per line (power of 2). Offset width OW = log2(WORDS_PER_BLOCK). Block width = 32*WORDS_PER_BLOCK.

Ports:
- CLK  input  1  system clock, rising edge active.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  32  byte address of the instruction to fetch.
- INSTRUCTION  output  32  fetched instruction. Valid while BUSYWAIT=0.
- BUSYWAIT  output  1  stall request to the PC stage and CPU.
- MEM_READ  output  1  read request to instruction memory.
- MEM_ADDRESS  output  ADDR_BITS-OW-2  block address to memory (6 bits at defaults).
- MEM_READDATA  input  32*WORDS_PER_BLOCK  block returned by memory.
- MEM_BUSYWAIT  input  1  memory busy; data valid in a cycle where it is low while MEM_READ=1.

Behaviour:
- Address split (defaults):
  - PC[1:0] is ignored.
  - Offset = PC[3:2], index = PC[6:4], tag = PC[9:7].
  - Tag width = ADDR_BITS-IW-OW-2.
- Storage per line: valid bit, tag, data block.
  - Word k of a block is bits [32k+31:32k]; word 0 is the lowest address.
- Hit detection is combinational: hit = valid[index] && (tag[index] == PC tag).
  - INSTRUCTION = selected word when hit, 32'h0 otherwise.
- FSM states: IDLE, READ_MEM, UPDATE.
  - IDLE: BUSYWAIT = !hit (combinational, same cycle as PC change); MEM_READ=0.
    - On a posedge with !hit: latch miss tag/index into a fill register; go to READ_MEM.
  - READ_MEM: MEM_READ=1, MEM_ADDRESS = {latched tag, latched index}, BUSYWAIT=1.
    - On a posedge with MEM_BUSYWAIT=0: capture MEM_READDATA into a fill buffer; go to UPDATE.
    - Otherwise stay in READ_MEM.
  - UPDATE: MEM_READ=0, BUSYWAIT=1.
    - On the posedge: write fill buffer, tag and valid=1 into the latched index; go to IDLE.
  - The next IDLE cycle hits, so BUSYWAIT falls and INSTRUCTION is valid.
- Miss penalty: 1 (IDLE) + N (READ_MEM, where N = cycles until MEM_BUSYWAIT is sampled low, minimum 1) + 1 (UPDATE) cycles of BUSYWAIT.
- Hit latency: zero cycles (combinational). The cache never issues a memory request on a hit.
- The fill uses only the latched tag/index, so PC glitches during READ_MEM/UPDATE cannot corrupt the fill. The PC stage still must hold PC while BUSYWAIT=1.
- MEM_ADDRESS outside READ_MEM holds its last value. It reads 0 after reset.
- Reset (async, any state, including mid-fill):
  - State goes to IDLE immediately.
  - All valid bits are cleared; tags and data are don't-care.
  - MEM_READ=0 and MEM_ADDRESS=0 immediately.
  - The fill buffer is discarded.
  - While RESET is high, BUSYWAIT=0 and INSTRUCTION=0.
  - After release, the first fetch misses.
- A memory response arriving while in IDLE or UPDATE is ignored.
- The cache never writes; there is no dirty state and no write-back.

Test Plan:
1. Cold miss: release RESET; PC=0; memory latency 5 cycles with MEM_READDATA=128'h00000003_00000002_00000001_00000000.
   - Required: BUSYWAIT=1 in the same cycle; MEM_READ=1 with MEM_ADDRESS=6'd0 from the next edge for 5 cycles.
   - Then UPDATE for 1 cycle; then BUSYWAIT=0 and INSTRUCTION=32'h00000000. Total stall is 7 cycles.
2. Same-block hits: after test 1, PC=4, 8, 12 on consecutive cycles.
   - Required: INSTRUCTION=1, 2, 3; BUSYWAIT=0 throughout; MEM_READ never asserted.
3. Conflict miss: PC=32'h80 (index 0, tag 1).
   - Required: miss, MEM_ADDRESS=6'd8; after the fill, INSTRUCTION equals word 0 of the new block.
   - Then PC=0 misses again with MEM_ADDRESS=6'd0.
4. Zero-latency memory: MEM_BUSYWAIT tied 0, PC=32'h10.
   - Required: READ_MEM lasts exactly 1 cycle and BUSYWAIT is high for exactly 3 cycles.
   - Line 1 is filled and PC=32'h14 then hits.
5. Reset mid-fill: assert RESET during cycle 2 of READ_MEM.
   - Required: MEM_READ=0 and BUSYWAIT=0 before the next edge.
   - After release, PC=0 (previously cached) misses and refetches.
6. Upper PC bits ignored: after PC=0 is cached, apply PC=32'h400.
   - Required: hit, same INSTRUCTION as PC=0, no memory request.

Source files
------------

// File: rtl/icache_fetch_unit_if.sv
// CPU-side fetch port and memory-side block-read port of the instruction cache.
// The slave modport is the cache's view; the master modport is the environment's view.
interface icache_fetch_unit_if #(
  parameter int unsigned ADDR_BITS       = 10,
  parameter int unsigned WORDS_PER_BLOCK = 4
);
  localparam int unsigned OW  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned MAW = ADDR_BITS - OW - 2;
  localparam int unsigned BW  = 32 * WORDS_PER_BLOCK;

  logic [31:0]    PC;
  logic [31:0]    INSTRUCTION;
  logic           BUSYWAIT;
  logic           MEM_READ;
  logic [MAW-1:0] MEM_ADDRESS;
  logic [BW-1:0]  MEM_READDATA;
  logic           MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_fetch_unit.sv
// Direct-mapped, read-only instruction cache with zero-latency hits.
// A miss stalls the PC stage while one block is fetched from instruction memory.
module icache_fetch_unit #(
  parameter int unsigned ADDR_BITS       = 10,
  parameter int unsigned NUM_BLOCKS      = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  icache_fetch_unit_if.slave   bus
);
  localparam int unsigned IW = $clog2(NUM_BLOCKS);
  localparam int unsigned OW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned TW = ADDR_BITS - IW - OW - 2;

  typedef logic [WORDS_PER_BLOCK-1:0][31:0] block_t;
  typedef enum logic [1:0] {IDLE, READ_MEM, UPDATE} state_t;

  state_t                state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [TW-1:0]         tag_q  [NUM_BLOCKS];
  logic [TW-1:0]         tag_d  [NUM_BLOCKS];
  block_t                data_q [NUM_BLOCKS];
  block_t                data_d [NUM_BLOCKS];
  logic [TW-1:0]         fill_tag_q, fill_tag_d;
  logic [IW-1:0]         fill_idx_q, fill_idx_d;
  block_t                fill_buf_q, fill_buf_d;

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic          hit_c;
  logic          busywait_c;
  logic          mem_read_c;
  logic          unused_pc_bits;

  // Address split; bits above ADDR_BITS and the byte offset play no part.
  assign pc_off         = bus.PC[OW+1:2];
  assign pc_idx         = bus.PC[OW+IW+1:OW+2];
  assign pc_tag         = bus.PC[ADDR_BITS-1:OW+IW+2];
  assign unused_pc_bits = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

  assign hit_c = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign bus.INSTRUCTION = hit_c ? data_q[pc_idx][pc_off] : 32'h0;
  // Reset clears every valid bit, so only the stall request needs explicit gating.
  assign bus.BUSYWAIT    = busywait_c & ~RESET;
  assign bus.MEM_READ    = mem_read_c;
  assign bus.MEM_ADDRESS = {fill_tag_q, fill_idx_q};

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    fill_buf_d = fill_buf_q;
    busywait_c = 1'b0;
    mem_read_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        busywait_c = !hit_c;
        if (!hit_c) begin
          fill_tag_d = pc_tag;
          fill_idx_d = pc_idx;
          state_d    = READ_MEM;
        end
      end
      READ_MEM: begin
        busywait_c = 1'b1;
        mem_read_c = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          fill_buf_d = block_t'(bus.MEM_READDATA);
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        busywait_c          = 1'b1;
        valid_d[fill_idx_q] = 1'b1;
        tag_d[fill_idx_q]   = fill_tag_q;
        data_d[fill_idx_q]  = fill_buf_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      fill_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      fill_buf_q <= fill_buf_d;
    end
  end

  // Tag and data arrays are qualified by the valid bits and need no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
